// File: rtl/scan_pkg.sv
// Shared definitions for the debugger-side scan path master.
package scan_pkg;

    // Scan master sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CAP_LO = 3'd1,
        ST_CAP_HI = 3'd2,
        ST_SH_LO  = 3'd3,
        ST_SH_HI  = 3'd4,
        ST_DONE   = 3'd5
    } scan_state_t;

    // scan_en levels seen by the DUT scanner.
    localparam logic SCAN_CAPTURE = 1'b0;
    localparam logic SCAN_SHIFT   = 1'b1;

    // Host access geometry: four 16-bit slices cover the longest legal chain.
    localparam int SLICE_W    = 16;
    localparam int NUM_SLICES = 4;
    localparam int WIDE_W     = SLICE_W * NUM_SLICES;

    // CPU identification shared with the debugger software.
    localparam logic [7:0] CPU_TYPE    = 8'h5C;
    localparam logic [7:0] CPU_SUBTYPE = 8'h03;

    // Lowest bit position of a host slice.
    function automatic int slice_lsb(input logic [1:0] sel);
        return int'(sel) * SLICE_W;
    endfunction

endpackage

// File: rtl/scan_phase_timer.sv
// Times one scan_clk phase: phase_end is high on the last of CLK_DIV cycles.
module scan_phase_timer #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic nreset,
    input  logic restart,
    output logic phase_end
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    // Cycle counter, cleared whenever the phase restarts.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign phase_end = (cnt == CW'(CLK_DIV - 1));

endmodule

// File: rtl/scan_master.sv
// Scan path master: capture pulse, then SCAN_LEN-bit shift with tx out / rx in.
module scan_master
    import scan_pkg::*;
#(
    parameter int SCAN_LEN = 30,
    parameter int CLK_DIV  = 2
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        start,
    input  logic        capture,
    output logic        busy,
    output logic        done,
    input  logic        wr_en,
    input  logic [1:0]  wr_sel,
    input  logic [15:0] wr_data,
    input  logic [1:0]  rd_sel,
    output logic [15:0] rd_data,
    output logic        scan_clk,
    output logic        scan_en,
    output logic        scan_in,
    input  logic        scan_out
);

    localparam int BW = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;

    scan_state_t         state_q;
    scan_state_t         state_d;
    logic                phase_end;
    logic                restart;
    logic [BW-1:0]       bit_q;
    logic                last_bit;
    logic [5:0]          nxt_idx;
    logic [SCAN_LEN-1:0] tx_q;
    logic [SCAN_LEN-1:0] tx_d;
    logic [SCAN_LEN-1:0] rx_q;
    logic [WIDE_W-1:0]   tx_wide;
    logic [WIDE_W-1:0]   rx_wide;
    logic                scan_in_q;

    assign last_bit = (bit_q == BW'(SCAN_LEN - 1));

    scan_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk       (clk),
        .nreset    (nreset),
        .restart   (restart),
        .phase_end (phase_end)
    );

    // State register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: each LO/HI phase advances on the timer tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = capture ? ST_CAP_LO : ST_SH_LO;
            ST_CAP_LO: if (phase_end) state_d = ST_CAP_HI;
            ST_CAP_HI: if (phase_end) state_d = ST_SH_LO;
            ST_SH_LO:  if (phase_end) state_d = ST_SH_HI;
            ST_SH_HI:  if (phase_end) state_d = last_bit ? ST_DONE : ST_SH_LO;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output decode; the phase timer restarts on every state change and idles clear.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        scan_clk = 1'b0;
        scan_en  = SCAN_CAPTURE;
        restart  = (state_d != state_q);
        case (state_q)
            ST_IDLE: begin
                restart = 1'b1;
            end
            ST_CAP_LO: begin
                busy = 1'b1;
            end
            ST_CAP_HI: begin
                busy     = 1'b1;
                scan_clk = 1'b1;
            end
            ST_SH_LO: begin
                busy    = 1'b1;
                scan_en = SCAN_SHIFT;
            end
            ST_SH_HI: begin
                busy     = 1'b1;
                scan_clk = 1'b1;
                scan_en  = SCAN_SHIFT;
            end
            ST_DONE: begin
                done    = 1'b1;
                restart = 1'b1;
            end
            default: begin
                restart = 1'b1;
            end
        endcase
    end

    // Bit counter: zero in IDLE, advances after each completed HI phase.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            bit_q <= '0;
        end else if (state_q == ST_IDLE) begin
            bit_q <= '0;
        end else if (state_q == ST_SH_HI && phase_end && !last_bit) begin
            bit_q <= bit_q + 1'b1;
        end
    end

    // Host write merged ahead of the register so a write alongside start is
    // already visible to the first shifted bit.  Bits past the chain are dropped.
    always_comb begin
        tx_wide = WIDE_W'(tx_q);
        if (wr_en && !busy) begin
            tx_wide[slice_lsb(wr_sel) +: SLICE_W] = wr_data;
        end
        tx_d = tx_wide[SCAN_LEN-1:0];
    end

    // Transmit register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tx_q <= '0;
        end else begin
            tx_q <= tx_d;
        end
    end

    // Bit to present when entering SH_LO: 0 on the first shift, else the next one.
    always_comb begin
        nxt_idx = 6'd0;
        if (state_q == ST_SH_HI) begin
            nxt_idx = 6'(bit_q) + 6'd1;
        end
    end

    // scan_in is loaded on SH_LO entry and held through SH_HI.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            scan_in_q <= 1'b0;
        end else if (state_d == ST_SH_LO && state_q != ST_SH_LO) begin
            scan_in_q <= tx_wide[nxt_idx];
        end
    end

    assign scan_in = scan_in_q;

    // Receive: sample scan_out just before the scan_clk rise shifts the chain.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rx_q <= '0;
        end else if (state_q == ST_SH_LO && phase_end) begin
            for (int i = 0; i < SCAN_LEN; i++) begin
                if (BW'(i) == bit_q) begin
                    rx_q[i] <= scan_out;
                end
            end
        end
    end

    // Host read slice; bits beyond the chain read as zero.
    always_comb begin
        rx_wide = WIDE_W'(rx_q);
        rd_data = rx_wide[slice_lsb(rd_sel) +: SLICE_W];
    end

endmodule

// File: tb/tb_scan_master.sv
// Bench for scan_master: a 30-bit scanner model on the main instance and a
// 1-bit, CLK_DIV=1 instance for the minimum configuration.
module tb_scan_master;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;

    logic        start = 1'b0, capture = 1'b0, wr_en = 1'b0;
    logic [1:0]  wr_sel = 2'd0, rd_sel = 2'd0;
    logic [15:0] wr_data = 16'd0;
    logic        busy, done, scan_clk, scan_en, scan_in, scan_out;
    logic [15:0] rd_data;

    logic        start1 = 1'b0, capture1 = 1'b0, wr_en1 = 1'b0, scan_out1 = 1'b0;
    logic [1:0]  wr_sel1 = 2'd0, rd_sel1 = 2'd0;
    logic [15:0] wr_data1 = 16'd0;
    logic        busy1, done1, scan_clk1, scan_en1, scan_in1;
    logic [15:0] rd_data1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q[$];
    logic [29:0] tx_model = 30'd0;
    logic [29:0] cap_val  = 30'd0;
    logic [29:0] chain;

    int   rise_cnt  = 0;
    int   rise1_cnt = 0;
    logic rise_en_hist [256];

    always #5 clk = ~clk;

    scan_master #(.SCAN_LEN(30), .CLK_DIV(2)) u_dut (
        .clk(clk), .nreset(nreset), .start(start), .capture(capture),
        .busy(busy), .done(done), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_sel(rd_sel), .rd_data(rd_data), .scan_clk(scan_clk), .scan_en(scan_en),
        .scan_in(scan_in), .scan_out(scan_out)
    );

    scan_master #(.SCAN_LEN(1), .CLK_DIV(1)) u_dut1 (
        .clk(clk), .nreset(nreset), .start(start1), .capture(capture1),
        .busy(busy1), .done(done1), .wr_en(wr_en1), .wr_sel(wr_sel1), .wr_data(wr_data1),
        .rd_sel(rd_sel1), .rd_data(rd_data1), .scan_clk(scan_clk1), .scan_en(scan_en1),
        .scan_in(scan_in1), .scan_out(scan_out1)
    );

    // Scanner model: parallel load on a capture rise, LSB-first shift otherwise.
    assign scan_out = chain[0];
    always @(posedge scan_clk) begin
        if (scan_en) chain <= {scan_in, chain[29:1]};
        else         chain <= cap_val;
        rise_en_hist[rise_cnt % 256] <= scan_en;
        rise_cnt <= rise_cnt + 1;
    end

    always @(posedge scan_clk1) rise1_cnt <= rise1_cnt + 1;

    // Expected rx slices for a 30-bit chain value.
    task automatic push_rx(input logic [29:0] v);
        logic [63:0] w;
        w = {34'd0, v};
        for (int s = 0; s < 4; s++) exp_q.push_back(w[s*16 +: 16]);
    endtask

    task automatic write_tx(input logic [1:0] sel, input logic [15:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_data = data;
        for (int i = 0; i < 16; i++)
            if (int'(sel) * 16 + i < 30) tx_model[int'(sel) * 16 + i] = data[i];
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Start one transaction on the main instance and wait (bounded) for done.
    task automatic run_txn(input logic cap, output int busy_n, output int done_n);
        start = 1'b1; capture = cap;
        @(negedge clk);
        start = 1'b0; capture = 1'b0; wr_en = 1'b0;
        busy_n = 0; done_n = 0;
        for (int i = 0; i < 2000; i++) begin
            if (busy) busy_n++;
            if (done) begin done_n++; break; end
            @(negedge clk);
        end
        repeat (3) begin
            @(negedge clk);
            if (done) done_n++;
        end
    endtask

    task automatic test_reset;
        nreset = 1'b0;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({scan_clk, scan_en, scan_in, busy, done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 00000", {scan_clk, scan_en, scan_in, busy, done});
        end
        for (int s = 0; s < 4; s++) begin
            rd_sel = 2'(s); #1;
            n_checks++;
            if (rd_data !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_rd%0d: got %h expected 0000", s, rd_data);
            end
        end
    endtask

    task automatic test_capture_shift;
        int bn, dn, r0;
        cap_val = {2'b10, 12'h123, 16'hA5C3};
        push_rx(cap_val);
        r0 = rise_cnt;
        run_txn(1'b1, bn, dn);
        n_checks++;
        if (bn != 124) begin n_fail++; $display("FAIL cap_busy_cycles: got %0d expected 124", bn); end
        n_checks++;
        if (dn != 1) begin n_fail++; $display("FAIL cap_done_pulses: got %0d expected 1", dn); end
        n_checks++;
        if (rise_cnt - r0 != 31) begin n_fail++; $display("FAIL cap_rises: got %0d expected 31", rise_cnt - r0); end
        n_checks++;
        if (rise_en_hist[r0 % 256] !== 1'b0 || rise_en_hist[(r0 + 1) % 256] !== 1'b1) begin
            n_fail++;
            $display("FAIL cap_first_rise_en: got %b%b expected 01", rise_en_hist[r0 % 256], rise_en_hist[(r0 + 1) % 256]);
        end
        for (int s = 0; s < 4; s++) begin
            logic [15:0] e;
            rd_sel = 2'(s); #1;
            e = exp_q.pop_front();
            n_checks++;
            if (rd_data !== e) begin n_fail++; $display("FAIL cap_rx%0d: got %h expected %h", s, rd_data, e); end
        end
    endtask

    task automatic test_shift_only;
        int bn, dn, r0;
        push_rx(chain);
        r0 = rise_cnt;
        // write with start in the same cycle: the transaction shifts the new value
        wr_en = 1'b1; wr_sel = 2'd0; wr_data = 16'h8001;
        tx_model[15:0] = 16'h8001;
        run_txn(1'b0, bn, dn);
        n_checks++;
        if (chain !== tx_model) begin n_fail++; $display("FAIL shift_chain: got %h expected %h", chain, tx_model); end
        n_checks++;
        if (rise_cnt - r0 != 30) begin n_fail++; $display("FAIL shift_rises: got %0d expected 30", rise_cnt - r0); end
        n_checks++;
        if (bn != 120 || dn != 1) begin n_fail++; $display("FAIL shift_busy_done: got %0d/%0d expected 120/1", bn, dn); end
        for (int s = 0; s < 4; s++) begin
            logic [15:0] e;
            rd_sel = 2'(s); #1;
            e = exp_q.pop_front();
            n_checks++;
            if (rd_data !== e) begin n_fail++; $display("FAIL shift_rx%0d: got %h expected %h", s, rd_data, e); end
        end
    endtask

    task automatic test_ignore_busy;
        int cyc, dn, late_busy;
        // bits 30/31 and slice 2 lie beyond the chain and must be discarded
        write_tx(2'd1, 16'hC00F);
        write_tx(2'd2, 16'hFFFF);
        push_rx(chain);
        start = 1'b1; capture = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; dn = 0;
        for (int i = 0; i < 2000; i++) begin
            if (busy) cyc++;
            start   = (cyc == 5 || cyc == 60);
            capture = start;
            wr_en   = (cyc == 20);
            wr_sel  = 2'd0;
            wr_data = 16'hFFFF;
            if (done) begin dn++; break; end
            @(negedge clk);
        end
        start = 1'b0; capture = 1'b0; wr_en = 1'b0;
        late_busy = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) dn++;
            if (busy) late_busy++;
        end
        n_checks++;
        if (cyc != 120) begin n_fail++; $display("FAIL busy_restart_cycles: got %0d expected 120", cyc); end
        n_checks++;
        if (dn != 1 || late_busy != 0) begin n_fail++; $display("FAIL busy_done_queue: got done=%0d busy_after=%0d expected 1/0", dn, late_busy); end
        n_checks++;
        if (chain !== tx_model) begin n_fail++; $display("FAIL busy_tx_unchanged: got %h expected %h", chain, tx_model); end
        for (int s = 0; s < 4; s++) begin
            logic [15:0] e;
            rd_sel = 2'(s); #1;
            e = exp_q.pop_front();
            n_checks++;
            if (rd_data !== e) begin n_fail++; $display("FAIL busy_rx%0d: got %h expected %h", s, rd_data, e); end
        end
    endtask

    task automatic test_abort;
        int cyc, bn, dn;
        start = 1'b1; capture = 1'b1;
        @(negedge clk);
        start = 1'b0; capture = 1'b0;
        cyc = 0;
        for (int i = 0; i < 2000 && cyc < 40; i++) begin
            if (busy) cyc++;
            if (cyc < 40) @(negedge clk);
        end
        nreset = 1'b0;
        tx_model = 30'd0;
        #1;
        n_checks++;
        if ({scan_clk, scan_en, busy, scan_in} !== 4'b0) begin
            n_fail++;
            $display("FAIL abort_outputs: got %b expected 0000 (cycle %0d)", {scan_clk, scan_en, busy, scan_in}, cyc);
        end
        for (int s = 0; s < 4; s++) begin
            rd_sel = 2'(s); #1;
            n_checks++;
            if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL abort_rx%0d: got %h expected 0000", s, rd_data); end
        end
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        cap_val = {2'b01, 12'hABC, 16'h1357};
        push_rx(cap_val);
        run_txn(1'b1, bn, dn);
        n_checks++;
        if (bn != 124 || dn != 1) begin n_fail++; $display("FAIL abort_next_txn: got %0d/%0d expected 124/1", bn, dn); end
        for (int s = 0; s < 4; s++) begin
            logic [15:0] e;
            rd_sel = 2'(s); #1;
            e = exp_q.pop_front();
            n_checks++;
            if (rd_data !== e) begin n_fail++; $display("FAIL abort_rx_after%0d: got %h expected %h", s, rd_data, e); end
        end
    endtask

    task automatic test_min_config;
        int bn, dn, r0;
        for (int k = 0; k < 2; k++) begin
            scan_out1 = (k == 0);
            exp_q.push_back({15'd0, scan_out1});
            for (int s = 1; s < 4; s++) exp_q.push_back(16'h0000);
            r0 = rise1_cnt;
            start1 = 1'b1; capture1 = 1'b0;
            @(negedge clk);
            start1 = 1'b0;
            bn = 0; dn = 0;
            for (int i = 0; i < 50; i++) begin
                if (busy1) bn++;
                if (done1) begin dn++; break; end
                @(negedge clk);
            end
            @(negedge clk);
            if (done1) dn++;
            n_checks++;
            if (bn != 2 || dn != 1) begin n_fail++; $display("FAIL min_busy_done: got %0d/%0d expected 2/1", bn, dn); end
            n_checks++;
            if (rise1_cnt - r0 != 1) begin n_fail++; $display("FAIL min_rises: got %0d expected 1", rise1_cnt - r0); end
            for (int s = 0; s < 4; s++) begin
                logic [15:0] e;
                rd_sel1 = 2'(s); #1;
                e = exp_q.pop_front();
                n_checks++;
                if (rd_data1 !== e) begin n_fail++; $display("FAIL min_rx%0d: got %h expected %h", s, rd_data1, e); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_capture_shift();
        test_shift_only();
        test_ignore_busy();
        test_abort();
        test_min_config();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
